// File: rtl/ov5642_pkg.sv
// Shared types and default timing constants for the OV5642 sensor-side transmitter.
package ov5642_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  localparam int unsigned DEF_H_ACTIVE    = 2560;
  localparam int unsigned DEF_H_BLANK     = 256;
  localparam int unsigned DEF_V_ACTIVE    = 720;
  localparam int unsigned DEF_VSYNC_LINES = 4;
  localparam int unsigned DEF_V_BACK      = 16;
  localparam int unsigned DEF_V_FRONT     = 4;
  localparam logic [7:0]  DEF_FILL_BYTE   = 8'h00;

  function automatic int unsigned max4(int unsigned a, int unsigned b,
                                       int unsigned c, int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov5642_axis_if.sv
// Byte-wide AXI-Stream carrying one video line per packet (tlast on the final byte).
interface ov5642_axis_if;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/ov5642_timing_gen.sv
// Horizontal/vertical counters and frame FSM; decodes which part of the frame the current cycle is in.
module ov5642_timing_gen
  import ov5642_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned V_FRONT     = DEF_V_FRONT
) (
  input  logic pclk,
  input  logic rstn,
  input  logic enable,
  output logic line_phase,
  output logic drain_phase,
  output logic vsync_phase,
  output logic frame_start_pulse,
  output logic last_byte_of_line
);

  localparam int unsigned LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int unsigned HW       = cnt_width(LINE_LEN);
  localparam int unsigned VW       = cnt_width(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT));
  localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);

  if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 ||
      VSYNC_LINES < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_param_check
    $error("ov5642_timing_gen: every timing parameter must be at least 1");
  end

  state_e         state_q, state_d;
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [VW-1:0]  seg_last;

  // Next-state logic: h wraps every line period, v wraps at the end of each vertical segment.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    seg_last = '0;
    unique case (state_q)
      ST_VSYNC:  seg_last = VW'(VSYNC_LINES - 1);
      ST_VBACK:  seg_last = VW'(V_BACK - 1);
      ST_ACTIVE: seg_last = VW'(V_ACTIVE - 1);
      ST_VFRONT: seg_last = VW'(V_FRONT - 1);
      default:   seg_last = '0;
    endcase

    if (state_q == ST_IDLE) begin
      h_d = '0;
      v_d = '0;
      if (enable) state_d = ST_VSYNC;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == seg_last) begin
        v_d = '0;
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        v_d = v_q + VW'(1);
      end
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // Counter and state registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (!rstn) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign line_phase        = (state_q == ST_ACTIVE) && (h_q < H_ACT_END);
  assign drain_phase       = ((state_q == ST_ACTIVE) && (h_q >= H_ACT_END)) || (state_q == ST_VFRONT);
  assign vsync_phase       = (state_q == ST_VSYNC);
  assign frame_start_pulse = (state_q == ST_VSYNC) && (h_q == '0) && (v_q == '0);
  assign last_byte_of_line = line_phase && (h_q == H_ACT_LAST);

endmodule

// File: rtl/ov5642_sensor_tx.sv
// OV5642 sensor-side transmitter: AXIS bytes in, registered din/href/vsync video bus out.
module ov5642_sensor_tx
  import ov5642_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK     = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter logic [7:0]  FILL_BYTE   = DEF_FILL_BYTE
) (
  input  logic                 pclk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 clr_status,
  ov5642_axis_if.slave         s_axis,
  output logic [7:0]           dout,
  output logic                 href,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 underflow,
  output logic                 tlast_err
);

  logic line_phase, drain_phase, vsync_phase, frame_start_pulse, last_byte_of_line;

  ov5642_timing_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_BLANK    (H_BLANK),
    .V_ACTIVE   (V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BACK     (V_BACK),
    .V_FRONT    (V_FRONT)
  ) u_timing (
    .pclk             (pclk),
    .rstn             (rstn),
    .enable           (enable),
    .line_phase       (line_phase),
    .drain_phase      (drain_phase),
    .vsync_phase      (vsync_phase),
    .frame_start_pulse(frame_start_pulse),
    .last_byte_of_line(last_byte_of_line)
  );

  logic [7:0] dout_q, dout_d;
  logic       href_q, href_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;
  logic       underflow_q, underflow_d;
  logic       tlast_err_q, tlast_err_d;
  logic       pad_q, pad_d;     // early tlast seen: rest of this line is filler
  logic       drop_q, drop_d;   // line overran: discard input up to its tlast
  logic       accept, accept_last, uf_set, te_set;

  // Ready is decoded from registered state only, so it never depends on tvalid.
  assign s_axis.tready = (line_phase && !pad_q) || (drain_phase && drop_q);
  assign accept        = s_axis.tready && s_axis.tvalid;
  assign accept_last   = accept && s_axis.tlast;

  // Output byte selection, line padding / drop tracking and sticky-flag updates.
  always_comb begin
    dout_d        = '0;
    href_d        = line_phase;
    vsync_d       = vsync_phase;
    frame_start_d = frame_start_pulse;
    pad_d         = pad_q;
    drop_d        = drop_q;
    uf_set        = 1'b0;
    te_set        = 1'b0;

    if (line_phase) begin
      if (pad_q) begin
        dout_d = FILL_BYTE;
      end else begin
        if (s_axis.tvalid) begin
          dout_d = s_axis.tdata;
        end else begin
          dout_d = FILL_BYTE;
          uf_set = 1'b1;
        end
        if (accept_last && !last_byte_of_line) begin
          te_set = 1'b1;
          pad_d  = 1'b1;
        end
        if (last_byte_of_line && !accept_last) te_set = 1'b1;
      end
      // Any stale drop is abandoned at line start; a fresh one starts on an overrun.
      drop_d = last_byte_of_line && !pad_q && !accept_last;
      if (last_byte_of_line) pad_d = 1'b0;
    end else if (drain_phase && drop_q && accept_last) begin
      drop_d = 1'b0;
    end

    underflow_d = clr_status ? 1'b0 : (underflow_q | uf_set);
    tlast_err_d = clr_status ? 1'b0 : (tlast_err_q | te_set);
  end

  // Output, flag and line-tracking registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!rstn) begin
      dout_q        <= '0;
      href_q        <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      tlast_err_q   <= 1'b0;
      pad_q         <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      dout_q        <= dout_d;
      href_q        <= href_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      tlast_err_q   <= tlast_err_d;
      pad_q         <= pad_d;
      drop_q        <= drop_d;
    end
  end

  assign dout        = dout_q;
  assign href        = href_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign tlast_err   = tlast_err_q;

endmodule

// File: tb/tb_ov5642_sensor_tx.sv
// Randomized scoreboard bench for ov5642_sensor_tx using a frame-position reference model.
module tb_ov5642_sensor_tx;

  localparam int HA = 8, HB = 4, VA = 3, VS = 1, VB = 1, VF = 1;
  localparam int L     = HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * L;
  localparam int NCYC  = 1500;
  localparam logic [7:0] FILL = 8'h00;

  logic       pclk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] dout;
  logic       href, vsync, frame_start, underflow, tlast_err;

  ov5642_axis_if s_axis ();

  ov5642_sensor_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF), .FILL_BYTE(FILL)
  ) dut (
    .pclk       (pclk),
    .rstn       (rstn),
    .enable     (enable),
    .clr_status (clr_status),
    .s_axis     (s_axis),
    .dout       (dout),
    .href       (href),
    .vsync      (vsync),
    .frame_start(frame_start),
    .underflow  (underflow),
    .tlast_err  (tlast_err)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [7:0] dout;
    logic       href;
    logic       vsync;
    logic       fs;
    logic       uf;
    logic       te;
    logic       ready;
  } exp_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  exp_t  exp_q[$];
  beat_t src_q[$];
  int    checks = 0;
  int    failures = 0;
  int    next_byte = 0;
  logic  hs_fired = 1'b0;

  // Reference model state: frame position in cycles, plus per-line bookkeeping.
  bit m_run = 0;
  int m_pos = 0;
  bit m_pad = 0;
  bit m_drop = 0;
  bit m_uf = 0;
  bit m_te = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add_line(input int n);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(beat_t'{last: (i == n - 1), data: 8'(next_byte)});
      next_byte++;
    end
  endtask

  // Segment of the frame for a given cycle position: 1 vsync, 2 back porch, 3 active, 4 front porch.
  function automatic int seg_of(input int pos);
    int line;
    line = pos / L;
    if (line < VS) return 1;
    if (line < VS + VB) return 2;
    if (line < VS + VB + VA) return 3;
    return 4;
  endfunction

  function automatic bit m_in_line();
    return m_run && seg_of(m_pos) == 3 && (m_pos % L) < HA;
  endfunction

  // Record the handshake as the DUT sees it at the edge.
  always @(posedge pclk) hs_fired = s_axis.tvalid && s_axis.tready;

  // Stimulus + reference model: drive one cycle, predict what the DUT shows after the next edge.
  initial begin
    int  lens[8];
    bit  reset_done;
    lens = '{8, 8, 8, 8, 5, 10, 7, 9};
    reset_done = 0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    for (int i = 0; i < 9; i++) add_line(8);
    add_line(5);
    add_line(8);
    add_line(10);
    for (int i = 0; i < 3; i++) add_line(8);

    for (int c = 0; c < NCYC; c++) begin
      int   col;
      bit   in_line, drain, ready, acc_last, uf_set, te_set;
      exp_t e;
      @(negedge pclk);
      if (hs_fired) void'(src_q.pop_front());
      while (src_q.size() < 24) add_line(lens[$urandom_range(0, 7)]);

      in_line = m_in_line();
      col     = m_pos % L;
      drain   = m_run && ((seg_of(m_pos) == 3 && col >= HA) || seg_of(m_pos) == 4);

      rstn = 1'b1;
      if (c < 3) rstn = 1'b0;
      if (c >= 950 && !reset_done && in_line) begin
        rstn = 1'b0;
        reset_done = 1;
      end
      enable     = !(c < 3) && !(c >= 700 && c < 800);
      clr_status = (c == 500 || c == 1100 || c == 1101);
      s_axis.tdata  = src_q[0].data;
      s_axis.tlast  = src_q[0].last;
      s_axis.tvalid = (c < 230) ? 1'b1 : ($urandom_range(0, 7) != 0);

      ready    = in_line ? !m_pad : (drain && m_drop);
      acc_last = ready && s_axis.tvalid && s_axis.tlast;
      e = '0;
      e.ready = ready;

      if (!rstn) begin
        m_run = 0; m_pos = 0; m_pad = 0; m_drop = 0; m_uf = 0; m_te = 0;
      end else begin
        e.href  = in_line;
        e.vsync = m_run && seg_of(m_pos) == 1;
        e.fs    = m_run && m_pos == 0;
        e.dout  = (in_line && !m_pad && s_axis.tvalid) ? s_axis.tdata : FILL;
        uf_set  = in_line && !m_pad && !s_axis.tvalid;
        te_set  = in_line && !m_pad && (acc_last ? (col != HA - 1) : (col == HA - 1));
        if (in_line) begin
          m_drop = (col == HA - 1) && !m_pad && !acc_last;
          m_pad  = (col == HA - 1) ? 0 : (m_pad || acc_last);
        end else if (drain && m_drop && acc_last) begin
          m_drop = 0;
        end
        m_uf = clr_status ? 0 : (m_uf || uf_set);
        m_te = clr_status ? 0 : (m_te || te_set);
        if (!m_run) begin
          if (enable) begin m_run = 1; m_pos = 0; end
        end else if (m_pos == FRAME - 1) begin
          if (enable) m_pos = 0;
          else m_run = 0;
        end else begin
          m_pos++;
        end
      end
      e.uf = m_uf;
      e.te = m_te;
      exp_q.push_back(e);
    end

    @(posedge pclk);
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: ready sampled just before the edge, registered outputs just after it.
  initial begin
    forever begin
      logic rdy;
      exp_t e;
      @(posedge pclk);
      rdy = s_axis.tready;
      #1;
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      check("s_tready",    8'(rdy),         8'(e.ready));
      check("dout",        dout,            e.dout);
      check("href",        8'(href),        8'(e.href));
      check("vsync",       8'(vsync),       8'(e.vsync));
      check("frame_start", 8'(frame_start), 8'(e.fs));
      check("underflow",   8'(underflow),   8'(e.uf));
      check("tlast_err",   8'(tlast_err),   8'(e.te));
    end
  end

endmodule
